// File: rtl/s_mem_pkg.sv
// Shared definitions for the blocks that sit on the 256-byte S memory
// (the initialiser and the permutation checker).
package s_mem_pkg;

   localparam int S_DEPTH  = 256;
   localparam int S_ADDR_W = 8;

   typedef enum logic [1:0] {
      INIT_IDLE,
      INIT_WRITE,
      INIT_DONE
   } init_state_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } perm_state_t;

endpackage

// File: rtl/perm_seen.sv
// 256-bit "value already seen" vector for the permutation checker.
// hit reports the flag for v as it stood before any set on this edge.
module perm_seen
   import s_mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                set,
   input  logic [S_ADDR_W-1:0] v,
   output logic                hit
);

   logic [S_DEPTH-1:0] seen;

   assign hit = seen[v];

   // Clear has priority so a new scan always starts from an empty vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= '0;
      end else if (clear) begin
         seen <= '0;
      end else if (set) begin
         seen[v] <= 1'b1;
      end
   end

endmodule

// File: rtl/perm_check.sv
// Scans the S memory 0..255 and checks it holds a permutation of 0..255.
// Optional macro PERM_CHECK_IDENTITY_EN: also require S[a] == a.
module perm_check
   import s_mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   output logic                rdy,
   output logic [S_ADDR_W-1:0] addr,
   input  logic [S_ADDR_W-1:0] rddata,
   output logic                ok,
   output logic                fail,
   output logic [S_ADDR_W-1:0] fail_addr
);

   perm_state_t         state, stateNext;
   logic [S_ADDR_W-1:0] addrNext;
   logic [S_ADDR_W-1:0] addrInc;
   logic                p0Valid, p0ValidNext;
   logic [S_ADDR_W-1:0] p0Addr, p0AddrNext;
   logic                p1Valid, p1ValidNext;
   logic [S_ADDR_W-1:0] p1Addr, p1AddrNext;
   logic                bad, badNext;
   logic                okNext, failNext;
   logic [S_ADDR_W-1:0] failAddrNext;
   logic                seenClear, seenSet, seenHit;
   logic                sampleFail;

   assign rdy     = (state == IDLE);
   assign addrInc = addr + 8'd1;

   perm_seen u_seen (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (seenClear),
      .set   (seenSet),
      .v     (rddata),
      .hit   (seenHit)
   );

   // Per-sample verdict for the address at the head of the read pipeline.
   always_comb begin
`ifdef PERM_CHECK_IDENTITY_EN
      sampleFail = seenHit | (rddata != p1Addr);
`else
      sampleFail = seenHit;
`endif
   end

   // Next-state logic: the pipeline head (p1) is the read whose data is on
   // rddata this cycle; p0 is the read issued on the previous edge.
   always_comb begin
      stateNext    = state;
      addrNext     = addr;
      p0ValidNext  = 1'b0;
      p0AddrNext   = addr;
      p1ValidNext  = p0Valid;
      p1AddrNext   = p0Addr;
      badNext      = bad;
      okNext       = ok;
      failNext     = fail;
      failAddrNext = fail_addr;
      seenClear    = 1'b0;
      seenSet      = 1'b0;

      if (p1Valid) begin
         seenSet = 1'b1;
         if (sampleFail && !bad) begin
            badNext      = 1'b1;
            failAddrNext = p1Addr;
         end
      end

      case (state)
         IDLE: begin
            addrNext = '0;
            if (en) begin
               stateNext    = READ;
               p0ValidNext  = 1'b1;
               p0AddrNext   = '0;
               okNext       = 1'b0;
               failNext     = 1'b0;
               failAddrNext = '0;
               badNext      = 1'b0;
               seenClear    = 1'b1;
            end
         end
         READ: begin
            addrNext    = addrInc;
            p0ValidNext = 1'b1;
            p0AddrNext  = addrInc;
            if (addrInc == 8'hFF) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (p1Valid && (p1Addr == 8'hFF)) begin
               stateNext = IDLE;
               okNext    = !(bad || sampleFail);
               failNext  = bad || sampleFail;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         p0Valid   <= 1'b0;
         p0Addr    <= '0;
         p1Valid   <= 1'b0;
         p1Addr    <= '0;
         bad       <= 1'b0;
         ok        <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
      end else begin
         state     <= stateNext;
         addr      <= addrNext;
         p0Valid   <= p0ValidNext;
         p0Addr    <= p0AddrNext;
         p1Valid   <= p1ValidNext;
         p1Addr    <= p1AddrNext;
         bad       <= badNext;
         ok        <= okNext;
         fail      <= failNext;
         fail_addr <= failAddrNext;
      end
   end

endmodule

// File: tb/tb_perm_check.sv
// Self-checking bench for perm_check with a behavioural S memory
// (2-edge read latency) and a reference model of the permutation rule.
module tb_perm_check;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       rdy;
   logic [7:0] addr;
   logic [7:0] rddata;
   logic       ok;
   logic       fail;
   logic [7:0] fail_addr;

   logic [7:0] mem [256];

   int passCount = 0;
   int totalCount = 0;

   typedef struct {
      string name;
      int    pattern;
      bit    expOk;
      bit    expFail;
      int    expFailAddr;
   } vec_t;

   vec_t vecs [4];

   perm_check dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .addr      (addr),
      .rddata    (rddata),
      .ok        (ok),
      .fail      (fail),
      .fail_addr (fail_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The DUT registers the address; the memory registers q once more, so
   // data for an address is on rddata two edges after the address changes.
   always @(posedge clk) begin
      rddata <= mem[addr];
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      totalCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic fillMem(input int pattern);
      int p, t, a, b;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      case (pattern)
         1: for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
         2: begin mem[40] = 8'd7; mem[200] = 8'd7; end
         3: mem[255] = 8'd3;
         4, 5: begin
            for (int i = 255; i > 0; i--) begin
               p = $urandom_range(i, 0);
               t = mem[i]; mem[i] = mem[p]; mem[p] = 8'(t);
            end
            if (pattern == 5) begin
               for (int k = 0; k < 2; k++) begin
                  a = $urandom_range(255, 0);
                  b = $urandom_range(255, 0);
                  mem[a] = mem[b];
               end
            end
         end
         6: for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(255, 0));
         default: ;
      endcase
   endtask

   // Reference: walk addresses in order, first repeated value (or, with the
   // identity option, first value differing from its address) is the failure.
   task automatic modelScan(output bit eOk, output bit eFail, output int eFailAddr);
      bit seenVals [256];
      bit bad;
      bit f;
      for (int v = 0; v < 256; v++) seenVals[v] = 1'b0;
      bad = 1'b0;
      eFailAddr = 0;
      for (int a = 0; a < 256; a++) begin
         f = seenVals[mem[a]];
`ifdef PERM_CHECK_IDENTITY_EN
         if (int'(mem[a]) != a) f = 1'b1;
`endif
         seenVals[mem[a]] = 1'b1;
         if (f && !bad) begin
            bad = 1'b1;
            eFailAddr = a;
         end
      end
      eOk = !bad;
      eFail = bad;
   endtask

   task automatic waitDone(input string name, input bit keepEn);
      int cycles = 0;
      int addrErr = 0;
      int midErr = 0;
      while (!rdy && cycles < 400) begin
         @(negedge clk);
         cycles++;
         if (!keepEn) en = 1'b0;
         if (cycles <= 255 && int'(addr) != cycles) addrErr++;
         if (!rdy && (ok || fail)) midErr++;
      end
      checkOutput({name, " scan cycles"}, cycles, 257);
      checkOutput({name, " addr sequence errors"}, addrErr, 0);
      checkOutput({name, " result during scan"}, midErr, 0);
   endtask

   task automatic applyStimulus(input string name, input bit keepEn);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      if (!keepEn) en = 1'b0;
      checkOutput({name, " rdy after start"}, int'(rdy), 0);
      checkOutput({name, " addr after start"}, int'(addr), 0);
      waitDone(name, keepEn);
   endtask

   task automatic checkResult(input string name, input bit eOk, input bit eFail, input int eFa);
      checkOutput({name, " rdy at end"}, int'(rdy), 1);
      checkOutput({name, " ok"}, int'(ok), int'(eOk));
      checkOutput({name, " fail"}, int'(fail), int'(eFail));
      checkOutput({name, " fail_addr"}, int'(fail_addr), eFa);
   endtask

   initial begin
      bit mOk, mFail;
      int mFa;

      vecs[0] = '{"identity", 0, 1'b1, 1'b0, 0};
`ifdef PERM_CHECK_IDENTITY_EN
      vecs[1] = '{"reverse", 1, 1'b0, 1'b1, 0};
`else
      vecs[1] = '{"reverse", 1, 1'b1, 1'b0, 0};
`endif
      vecs[2] = '{"dup40_200", 2, 1'b0, 1'b1, 40};
      vecs[3] = '{"last_bad", 3, 1'b0, 1'b1, 255};

      en = 1'b0;
      rst_n = 1'b0;
      fillMem(0);
      #12;
      checkOutput("reset rdy", int'(rdy), 1);
      checkOutput("reset addr", int'(addr), 0);
      checkOutput("reset ok", int'(ok), 0);
      checkOutput("reset fail", int'(fail), 0);
      checkOutput("reset fail_addr", int'(fail_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         fillMem(vecs[i].pattern);
         applyStimulus(vecs[i].name, 1'b0);
         checkResult(vecs[i].name, vecs[i].expOk, vecs[i].expFail, vecs[i].expFailAddr);
      end

      for (int r = 0; r < 6; r++) begin
         fillMem(4 + (r % 3));
         modelScan(mOk, mFail, mFa);
         applyStimulus($sformatf("random%0d", r), 1'b0);
         checkResult($sformatf("random%0d", r), mOk, mFail, mFa);
      end

      // Reset in the middle of a failing scan discards the partial result.
      fillMem(2);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset rdy", int'(rdy), 1);
      checkOutput("midreset addr", int'(addr), 0);
      checkOutput("midreset ok", int'(ok), 0);
      checkOutput("midreset fail", int'(fail), 0);
      checkOutput("midreset fail_addr", int'(fail_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      fillMem(0);
      applyStimulus("after_reset", 1'b0);
      checkResult("after_reset", 1'b1, 1'b0, 0);

      // en held high: ok visible for one cycle, then the next scan starts.
      applyStimulus("held_en", 1'b1);
      checkResult("held_en", 1'b1, 1'b0, 0);
      @(negedge clk);
      checkOutput("held_en restart rdy", int'(rdy), 0);
      checkOutput("held_en restart ok", int'(ok), 0);
      checkOutput("held_en restart addr", int'(addr), 0);
      en = 1'b0;
      waitDone("held_en second", 1'b0);
      checkResult("held_en second", 1'b1, 1'b0, 0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
